// File: rtl/mcycle_ctrl_if.sv
// mcycle_ctrl_if: memory request/ready handshake between the multicycle
// control unit and the shared instruction/data memory.
//   MemReq    controller -> memory  access request
//   MemWrite  controller -> memory  the request is a store
//   AdrSrc    controller -> memory  address select (0 = PC, 1 = ALUOut)
//   MemReady  memory -> controller  access completes this cycle
interface mcycle_ctrl_if;
  logic MemReq;
  logic MemWrite;
  logic AdrSrc;
  logic MemReady;

  modport master (
    output MemReq,
    output MemWrite,
    output AdrSrc,
    input  MemReady
  );

  modport slave (
    input  MemReq,
    input  MemWrite,
    input  AdrSrc,
    output MemReady
  );
endinterface

// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: multicycle RV32I control unit. Sequences each instruction
// through fetch/decode/execute/memory/writeback and drives the shared-memory
// multicycle datapath. Also keeps a retired-instruction counter and a memory
// wait watchdog.
//
// Optional feature: define MCYCLE_CTRL_TRAP_EN to trap illegal opcodes
// (IllegalOp set, FSM halts). Without it an illegal opcode retires as a NOP.
//
// Parameters:
//   CNT_W        width of InstRet
//   MEM_TIMEOUT  max wait cycles in a memory state (0 disables watchdog)
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   op                    opcode of the instruction register
//   BranchTaken           branch condition from the datapath comparator
//   mem                   memory handshake (MemReq/MemWrite/AdrSrc/MemReady)
//   IRWrite, PCWrite      instruction register / PC write enables
//   RegWrite              register file write enable
//   ResultSrc             result mux select
//   ALUSrcA, ALUSrcB      ALU operand selects
//   ALUOp                 ALU operation class
//   ImmSrc                immediate format, decoded from op
//   IllegalOp, MemTimeout sticky fault flags
//   Halted                FSM is in HALT
//   InstRet               retired instruction count
module mcycle_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             BranchTaken,
  mcycle_ctrl_if.master    mem,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             IllegalOp,
  output logic             MemTimeout,
  output logic             Halted,
  output logic [CNT_W-1:0] InstRet
);

`ifdef MCYCLE_CTRL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // Wide enough to hold MEM_TIMEOUT itself; at least one bit when disabled.
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 2);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, LINKWB, LUIWB, HALT
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                is_wait;
  logic                wait_expire;
  logic                timeout_hit;
  logic                op_legal;
  logic                illegal_q;
  logic                timeout_q;
  logic [CNT_W-1:0]    inst_ret_q;

  assign is_wait     = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  assign wait_expire = (MEM_TIMEOUT != 0) &&
                       ((32'(wait_cnt) + 32'd1) == 32'(MEM_TIMEOUT));
  assign op_legal    = op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BR,
                                  OP_JAL, OP_JALR, OP_AUIPC, OP_LUI};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Next-state logic; MemReady takes priority over an expiring watchdog
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      FETCH: begin
        if (mem.MemReady) state_next = DECODE;
        else if (wait_expire) begin
          state_next  = HALT;
          timeout_hit = 1'b1;
        end
      end
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECR;
          OP_ITYPE:          state_next = EXECI;
          OP_BR:             state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          OP_JALR:           state_next = JALR;
          OP_AUIPC:          state_next = ALUWB;
          OP_LUI:            state_next = LUIWB;
          default:           state_next = TRAP_EN ? HALT : FETCH;
        endcase
      end
      MEMADR:   state_next = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD: begin
        if (mem.MemReady) state_next = MEMWB;
        else if (wait_expire) begin
          state_next  = HALT;
          timeout_hit = 1'b1;
        end
      end
      MEMWRITE: begin
        if (mem.MemReady) state_next = FETCH;
        else if (wait_expire) begin
          state_next  = HALT;
          timeout_hit = 1'b1;
        end
      end
      MEMWB:    state_next = FETCH;
      EXECR:    state_next = ALUWB;
      EXECI:    state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
      JAL:      state_next = LINKWB;
      JALR:     state_next = LINKWB;
      LINKWB:   state_next = FETCH;
      LUIWB:    state_next = FETCH;
      HALT:     state_next = HALT;
      default:  state_next = FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    mem.MemReq   = 1'b0;
    mem.MemWrite = 1'b0;
    mem.AdrSrc   = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    case (state)
      FETCH: begin
        mem.MemReq = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        IRWrite    = mem.MemReady;
        PCWrite    = mem.MemReady;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        mem.MemReq = 1'b1;
        mem.AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        mem.MemReq   = 1'b1;
        mem.MemWrite = 1'b1;
        mem.AdrSrc   = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      ALUWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = BranchTaken;
      end
      JAL: PCWrite = 1'b1;
      JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      LINKWB: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegWrite  = 1'b1;
      end
      LUIWB: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:        ImmSrc = 3'b001;
      OP_BR:           ImmSrc = 3'b010;
      OP_JAL:          ImmSrc = 3'b011;
      OP_AUIPC, OP_LUI: ImmSrc = 3'b100;
      default:         ImmSrc = 3'b000;
    endcase
  end

  // Wait counter restarts on every state change, so it only accumulates
  // while parked in FETCH/MEMREAD/MEMWRITE waiting for MemReady.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= '0;
      inst_ret_q <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_next != state)
        wait_cnt <= '0;
      else if (is_wait && !mem.MemReady)
        wait_cnt <= wait_cnt + WAIT_W'(1);

      if (state != FETCH && state_next == FETCH)
        inst_ret_q <= inst_ret_q + CNT_W'(1);

      if (TRAP_EN && state == DECODE && !op_legal)
        illegal_q <= 1'b1;

      if (timeout_hit)
        timeout_q <= 1'b1;
    end
  end

  assign IllegalOp  = illegal_q;
  assign MemTimeout = timeout_q;
  assign Halted     = (state == HALT);
  assign InstRet    = inst_ret_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb_mcycle_ctrl: randomized bench for mcycle_ctrl. A per-instruction
// reference model predicts cycle count, strobe counts, writeback source and
// retirement from the opcode class and the memory wait cycles the bench picks.
module tb_mcycle_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic        BranchTaken;
  logic        IRWrite, PCWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0]  ImmSrc;
  logic        IllegalOp, MemTimeout, Halted;
  logic [31:0] InstRet;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] retired = '0;

  always #5 clk = ~clk;

  mcycle_ctrl_if bus ();

  mcycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .op(op), .BranchTaken(BranchTaken), .mem(bus),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .IllegalOp(IllegalOp), .MemTimeout(MemTimeout),
    .Halted(Halted), .InstRet(InstRet)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: instruction-level behaviour by opcode
  function automatic int unsigned base_cycles(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111: return 4;
      7'b1100011, 7'b0010111, 7'b0110111: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit is_mem(input logic [6:0] o);
    return (o == 7'b0000011) || (o == 7'b0100011);
  endfunction

  function automatic int unsigned reg_writes(input logic [6:0] o);
    return (o inside {7'b0000011, 7'b0110011, 7'b0010011, 7'b1101111,
                      7'b1100111, 7'b0010111, 7'b0110111}) ? 1 : 0;
  endfunction

  function automatic logic [1:0] wb_src(input logic [6:0] o);
    case (o)
      7'b0000011: return 2'b01;
      7'b0110111: return 2'b11;
      7'b1101111, 7'b1100111: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic int unsigned pc_writes(input logic [6:0] o, input logic tk);
    if (o == 7'b1101111 || o == 7'b1100111) return 2;
    if (o == 7'b1100011 && tk) return 2;
    return 1;
  endfunction

  // ResultSrc seen on the last PC write of the instruction
  function automatic logic [1:0] pc_src(input logic [6:0] o, input logic tk);
    if (o == 7'b1101111) return 2'b00;
    if (o == 7'b1100011 && tk) return 2'b00;
    return 2'b10;
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0010111, 7'b0110111: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.MemReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    retired = '0;
  endtask

  // Starts at a negedge in the first FETCH cycle; returns at the negedge of
  // the next FETCH. wf/wm = not-ready cycles before fetch/data completion.
  task automatic run_instr(input logic [6:0] o, input logic tk,
                           input int unsigned wf, input int unsigned wm);
    int unsigned cyc = 0, acc = 0, cnt = 0;
    int unsigned irw = 0, pcw = 0, rgw = 0, st = 0, rw_cyc = 0;
    logic [1:0] rs = '0, sa = '0, sb = '0, ps = '0;
    logic [2:0] imm = '0;
    bit done = 1'b0;
    string t;
    op = o;
    BranchTaken = tk;
    while (!done && cyc < 64) begin
      if (bus.MemReq) bus.MemReady = (cnt == ((acc == 0) ? wf : wm));
      else            bus.MemReady = 1'($urandom);
      #1;
      cyc++;
      if (cyc == 1) imm = ImmSrc;
      if (IRWrite) irw++;
      if (PCWrite) begin pcw++; ps = ResultSrc; end
      if (RegWrite) begin
        rgw++; rs = ResultSrc; sa = ALUSrcA; sb = ALUSrcB; rw_cyc = cyc;
      end
      if (bus.MemReq && bus.MemWrite && bus.MemReady) st++;
      if (bus.MemReq) begin
        if (bus.MemReady) begin acc++; cnt = 0; end
        else cnt++;
      end
      @(posedge clk);
      @(negedge clk);
      if (Halted || (bus.MemReq && !bus.AdrSrc && acc >= 1)) done = 1'b1;
    end
    retired++;
    t = $sformatf("op=%b wf=%0d wm=%0d", o, wf, wm);
    check({"done ", t}, 32'(done), 32'd1);
    check({"cycles ", t}, cyc, base_cycles(o) + wf + (is_mem(o) ? wm : 0));
    check({"irwrite ", t}, irw, 32'd1);
    check({"pcwrite ", t}, pcw, pc_writes(o, tk));
    check({"pcsrc ", t}, 32'(ps), 32'(pc_src(o, tk)));
    check({"regwrite ", t}, rgw, reg_writes(o));
    check({"stores ", t}, st, (o == 7'b0100011) ? 32'd1 : 32'd0);
    check({"immsrc ", t}, 32'(imm), 32'(imm_of(o)));
    check({"instret ", t}, InstRet, retired);
    if (reg_writes(o) == 1) begin
      check({"wbsrc ", t}, 32'(rs), 32'(wb_src(o)));
      check({"wbcycle ", t}, rw_cyc, cyc);
    end
    if (o == 7'b1101111 || o == 7'b1100111) begin
      check({"link_a ", t}, 32'(sa), 32'd1);
      check({"link_b ", t}, 32'(sb), 32'd2);
    end
  endtask

  logic [6:0] op_tab [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                             7'b1100011, 7'b1101111, 7'b1100111, 7'b0010111,
                             7'b0110111};

  initial begin
    int unsigned fc;
    op = 7'b0010011;
    BranchTaken = 1'b0;
    do_reset();
    #1;
    check("rst memreq", 32'(bus.MemReq), 32'd1);
    check("rst adrsrc", 32'(bus.AdrSrc), 32'd0);
    check("rst memwrite", 32'(bus.MemWrite), 32'd0);
    check("rst irwrite", 32'(IRWrite), 32'd0);
    check("rst instret", InstRet, 32'd0);
    check("rst flags", {29'd0, IllegalOp, MemTimeout, Halted}, 32'd0);

    run_instr(7'b0000011, 1'b0, 2, 1);
    run_instr(7'b1100011, 1'b1, 0, 0);
    run_instr(7'b1100011, 1'b0, 0, 0);
    run_instr(7'b1101111, 1'b0, 0, 0);
    run_instr(7'b0110111, 1'b0, 0, 0);
    run_instr(7'b0100011, 1'b0, 3, 3);

    for (int i = 0; i < 40; i++) begin
      run_instr(op_tab[$urandom_range(0, 8)], 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Illegal opcode, zero-wait fetch
    op = 7'b0000000;
    bus.MemReady = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.MemReady = 1'b0;
    @(posedge clk); @(negedge clk);
    #1;
`ifdef MCYCLE_CTRL_TRAP_EN
    check("ill flag", 32'(IllegalOp), 32'd1);
    check("ill halted", 32'(Halted), 32'd1);
    check("ill instret", InstRet, retired);
`else
    retired++;
    check("ill flag", 32'(IllegalOp), 32'd0);
    check("ill refetch", 32'(bus.MemReq && !bus.AdrSrc), 32'd1);
    check("ill instret", InstRet, retired);
`endif

    // Watchdog: MemReady held low from a fresh fetch
    do_reset();
    fc = 0;
    for (int i = 0; i < 20; i++) begin
      bus.MemReady = 1'b0;
      #1;
      if (Halted) break;
      if (bus.MemReq) fc++;
      @(posedge clk); @(negedge clk);
    end
    check("wd fetch cycles", fc, 32'd4);
    check("wd timeout", 32'(MemTimeout), 32'd1);
    check("wd halted", 32'(Halted), 32'd1);
    check("wd memreq", 32'(bus.MemReq), 32'd0);
    bus.MemReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("halt sticky", 32'(Halted), 32'd1);
    check("halt instret", InstRet, 32'd0);

    do_reset();
    #1;
    check("post memreq", 32'(bus.MemReq), 32'd1);
    check("post flags", {29'd0, IllegalOp, MemTimeout, Halted}, 32'd0);
    check("post instret", InstRet, 32'd0);
    run_instr(7'b0010111, 1'b0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mcycle_ctrl.md
# mcycle_ctrl

Multicycle RV32I control unit: the sequential successor of the single-cycle main decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states and drives the shared-memory multicycle datapath. Memory access uses a req/ready handshake, so memory latency is variable. The block also provides a retired-instruction counter, a memory-timeout watchdog and optional illegal-opcode trapping.

## Interface
- CNT_W, 32: width of the retired-instruction counter.
- MEM_TIMEOUT, 16: maximum cycles spent waiting for MemReady in any memory state; 0 disables the watchdog.
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high.
- op  in  7  opcode field of the instruction register.
- BranchTaken  in  1  branch condition from the datapath comparator (funct3 already applied).
- MemReady  in  1  memory completes the current access this cycle.
- MemReq  out  1  memory access request.
- MemWrite  out  1  the request is a store.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  latch instruction and OldPC.
- PCWrite  out  1  load PC from Result.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4.
- ALUOp  out  2  00 = add, 01 = branch compare/sub, 10 = decode from funct.
- ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- IllegalOp  out  1  sticky illegal-opcode flag.
- MemTimeout  out  1  sticky watchdog flag.
- Halted  out  1  FSM is in HALT.
- InstRet  out  CNT_W  count of retired instructions.

## Operation
- Moore FSM with a 4-bit state. Any output not listed for a state is 0. ImmSrc is always decoded from op (lw/jalr/I-ALU → 000, S → 001, B → 010, jal → 011, auipc/lui → 100, other → 000).
- FETCH:
  - Outputs: MemReq, AdrSrc=0, A=00, B=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCWrite are asserted only in the cycle MemReady=1. The next state is then DECODE; otherwise the FSM stays in FETCH.
- DECODE: A=01, B=01, ALUOp=00. Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0010111 → ALUWB
  - 0110111 → LUIWB
  - any other op → illegal handling (see Configuration).
- MEMADR: A=10, B=01. Next state is MEMREAD if op[5]=0, MEMWRITE otherwise.
- MEMREAD: MemReq, AdrSrc=1. Waits for MemReady, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite; then FETCH.
- MEMWRITE: MemReq, MemWrite, AdrSrc=1. Waits for MemReady, then goes to FETCH.
- EXECR: A=10, B=00, ALUOp=10; then ALUWB.
- EXECI: A=10, B=01, ALUOp=10; then ALUWB.
- ALUWB: ResultSrc=00, RegWrite; then FETCH.
- BRANCH: A=10, B=00, ALUOp=01, ResultSrc=00, PCWrite=BranchTaken; then FETCH.
- JAL: ResultSrc=00, PCWrite; then LINKWB.
- JALR: A=10, B=01, ALUOp=00, ResultSrc=10, PCWrite; then LINKWB.
- LINKWB: A=01, B=10, ResultSrc=10, RegWrite; then FETCH.
- LUIWB: ResultSrc=11, RegWrite; then FETCH.
- HALT: all control outputs 0, Halted=1. The FSM leaves HALT only on reset.
- Retirement:
  - InstRet increments by 1 on every transition into FETCH from a non-FETCH state.
  - It wraps modulo 2^CNT_W.
- Watchdog:
  - A wait counter clears on entry to FETCH, MEMREAD and MEMWRITE.
  - It increments on each cycle in those states with MemReady=0.
  - On the cycle it would reach MEM_TIMEOUT, MemTimeout is set and the next state is HALT. MemReq drops the next cycle.

## Timing
- Reset (synchronous): state=FETCH, InstRet=0, IllegalOp=0, MemTimeout=0, wait counter=0. MemReq is therefore 1 in the first cycle after reset is released.
- Cycles per instruction with zero-wait memory (MemReady=1 on the first request cycle):
  - lw: 5
  - sw: 4
  - R/I-ALU: 4
  - branch: 3
  - jal/jalr: 4
  - auipc: 3
  - lui: 3
- Each wait cycle adds 1.
- Handshake:
  - MemReq, MemWrite and AdrSrc are held stable until the cycle MemReady=1.
  - MemReady is ignored in states without MemReq.
- Reset asserted mid-access takes priority: the FSM goes to FETCH on the next edge and no write strobes are issued in that cycle's aftermath.
- Watchdog and MemReady in the same cycle: MemReady wins and the access completes.

## Configuration
- MCYCLE_CTRL_TRAP_EN defined: an illegal op in DECODE sets IllegalOp and goes to HALT. The instruction is not retired.
- MCYCLE_CTRL_TRAP_EN not defined: an illegal op goes DECODE → FETCH as a NOP and is retired (InstRet increments). IllegalOp stays 0.

## Test plan
- lw (op=0000011) with MemReady low for 2 cycles in FETCH and 1 cycle in MEMREAD → state path FETCH×3, DECODE, MEMADR, MEMREAD×2, MEMWB. RegWrite=1 with ResultSrc=01 in cycle 8; InstRet=1.
- beq (op=1100011) with BranchTaken=1, then with BranchTaken=0 → PCWrite=1 then 0 in the BRANCH cycle. Each instruction takes 3 cycles.
- jal (op=1101111), zero-wait → DECODE ImmSrc=011; JAL cycle PCWrite=1 with ResultSrc=00; LINKWB RegWrite=1 with A=01, B=10, ResultSrc=10.
- lui (op=0110111) → LUIWB RegWrite=1, ResultSrc=11, ImmSrc=100; InstRet increments after 3 cycles.
- op=0000000:
  - With TRAP_EN: IllegalOp=1 and Halted=1 two cycles after the fetch completes, InstRet unchanged.
  - Without TRAP_EN: back in FETCH, InstRet +1.
- MEM_TIMEOUT=4 with MemReady held 0 → MemTimeout=1 and Halted=1 after 4 FETCH cycles. Reset then returns the FSM to FETCH with all flags 0.
